// File: rtl/inst_set_pkg.sv
// inst_set: shared instruction-set constants, field positions and opcode classification.
// No ports; imported by the decode stage and its operand mux.
package inst_set;
    localparam logic [5:0] INST_J = 6'h02;
    localparam int REGW    = 5;
    localparam int OP_HI   = 31;
    localparam int OP_LO   = 26;
    localparam int FP_BIT  = 30;
    localparam int BANK_HI = 29;
    localparam int BANK_LO = 26;
    localparam int RD_HI   = 25;
    localparam int RD_LO   = 21;
    localparam int RA_HI   = 20;
    localparam int RA_LO   = 16;
    localparam int RB_HI   = 15;
    localparam int RB_LO   = 11;
    localparam int OFF_HI  = 15;
    localparam int OFF_LO  = 0;

    function automatic logic is_branch_inst(input logic [5:0] op);
        return op inside {6'h04, 6'h05, 6'h06, 6'h07};
    endfunction
endpackage

// File: rtl/decode_pipe_fwd_mux.sv
// fwd_mux: picks an operand from the lowest-numbered matching forwarding port, else dflt.
// Ports: valid/no/fmode_vec/data_vec = forwarding ports; sel_no/sel_fmode = register wanted;
//        dflt = fallback data; data = selected operand.
module fwd_mux
    import inst_set::*;
#(
    parameter int XLEN = 32,
    parameter int NFWD = 2
) (
    input  logic [NFWD-1:0]      valid,
    input  logic [NFWD*REGW-1:0] no,
    input  logic [NFWD-1:0]      fmode_vec,
    input  logic [NFWD*XLEN-1:0] data_vec,
    input  logic [REGW-1:0]      sel_no,
    input  logic                 sel_fmode,
    input  logic [XLEN-1:0]      dflt,
    output logic [XLEN-1:0]      data
);
    // Integer r0 is hardwired zero, so it never takes forwarded data.
    logic fwd_ok;
    assign fwd_ok = sel_fmode || (sel_no != '0);

    // Walk from the highest port down so the lowest matching port is written last.
    always_comb begin
        data = dflt;
        for (int i = NFWD - 1; i >= 0; i--)
            if (fwd_ok && valid[i] && no[i*REGW +: REGW] == sel_no && fmode_vec[i] == sel_fmode)
                data = data_vec[i*XLEN +: XLEN];
    end
endmodule

// File: rtl/decode_pipe.sv
// decode_pipe: one-entry decode stage; splits the instruction, reads/forwards operands,
// refreshes held operands while stalled and counts stall cycles.
// Ports: clk/rstn (sync, active-low); flush; in_valid/in_ready + pc/command upstream;
//        reg1/reg2/fmode1/fmode2 -> regfile, reg_out1/reg_out2 <- regfile;
//        fwd_* forwarding ports; out_valid/out_ready + decoded bundle downstream; stall_cnt.
module decode_pipe
    import inst_set::*;
#(
    parameter int XLEN = 32,
    parameter int NFWD = 2,
    parameter int CNTW = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      pc,
    input  logic [31:0]          command,
    output logic [4:0]           reg1,
    output logic [4:0]           reg2,
    output logic                 fmode1,
    output logic                 fmode2,
    input  logic [XLEN-1:0]      reg_out1,
    input  logic [XLEN-1:0]      reg_out2,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD*5-1:0]    fwd_no,
    input  logic [NFWD-1:0]      fwd_fmode,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [5:0]           opecode,
    output logic [15:0]          offset,
    output logic [XLEN-1:0]      pc_out,
    output logic [XLEN-1:0]      rs,
    output logic [XLEN-1:0]      rt,
    output logic [4:0]           rd_no,
    output logic [4:0]           rs_no,
    output logic [4:0]           rt_no,
    output logic                 fmode1_reg,
    output logic                 fmode2_reg,
    output logic [CNTW-1:0]      stall_cnt
);
    logic [XLEN-1:0] cap_rs, cap_rt, ref_rs, ref_rt;
    logic            cap, stalled, bank_zero;

    // Bank-zero and branch formats carry the second source in the rd field.
    assign bank_zero = command[BANK_HI:BANK_LO] == '0;
    assign reg1      = command[RA_HI:RA_LO];
    assign reg2      = (bank_zero || is_branch_inst(command[OP_HI:OP_LO])) ? command[RD_HI:RD_LO]
                                                                         : command[RB_HI:RB_LO];
    assign fmode1    = command[FP_BIT] && !bank_zero;
    assign fmode2    = command[FP_BIT];
    assign in_ready  = !out_valid || out_ready;
    assign cap       = in_valid && in_ready;
    assign stalled   = out_valid && !out_ready;

    fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_cap_rs (
        .valid(fwd_valid), .no(fwd_no), .fmode_vec(fwd_fmode), .data_vec(fwd_data),
        .sel_no(reg1), .sel_fmode(fmode1), .dflt(reg_out1), .data(cap_rs)
    );
    fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_cap_rt (
        .valid(fwd_valid), .no(fwd_no), .fmode_vec(fwd_fmode), .data_vec(fwd_data),
        .sel_no(reg2), .sel_fmode(fmode2), .dflt(reg_out2), .data(cap_rt)
    );
    // Refresh muxes default to the held value, so a miss leaves the operand unchanged.
    fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_ref_rs (
        .valid(fwd_valid), .no(fwd_no), .fmode_vec(fwd_fmode), .data_vec(fwd_data),
        .sel_no(rs_no), .sel_fmode(fmode1_reg), .dflt(rs), .data(ref_rs)
    );
    fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_ref_rt (
        .valid(fwd_valid), .no(fwd_no), .fmode_vec(fwd_fmode), .data_vec(fwd_data),
        .sel_no(rt_no), .sel_fmode(fmode2_reg), .dflt(rt), .data(ref_rt)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid  <= 1'b0;
            opecode    <= INST_J;
            offset     <= '0;
            pc_out     <= '0;
            rs         <= '0;
            rt         <= '0;
            rd_no      <= '0;
            rs_no      <= '0;
            rt_no      <= '0;
            fmode1_reg <= 1'b0;
            fmode2_reg <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            if (stalled && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush) begin
                out_valid <= 1'b0;
                opecode   <= INST_J;
            end else if (cap) begin
                out_valid  <= 1'b1;
                opecode    <= command[OP_HI:OP_LO];
                offset     <= command[OFF_HI:OFF_LO];
                pc_out     <= pc;
                rd_no      <= command[RD_HI:RD_LO];
                rs_no      <= reg1;
                rt_no      <= reg2;
                fmode1_reg <= fmode1;
                fmode2_reg <= fmode2;
                rs         <= cap_rs;
                rt         <= cap_rt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end else if (out_valid) begin
                rs <= ref_rs;
                rt <= ref_rt;
            end
        end
    end
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed self-checking bench for decode_pipe (main instance plus a CNTW=4 copy).
module tb_decode_pipe;
    logic        clk = 0, rstn = 0, flush = 0, in_valid = 0, out_ready = 1;
    logic [31:0] pc = 0, command = 0, reg_out1 = 0, reg_out2 = 0;
    logic [1:0]  fwd_valid = 0, fwd_fmode = 0;
    logic [9:0]  fwd_no = 0;
    logic [63:0] fwd_data = 0;
    logic        in_ready, fmode1, fmode2, out_valid, fmode1_reg, fmode2_reg;
    logic [4:0]  reg1, reg2, rd_no, rs_no, rt_no;
    logic [5:0]  opecode;
    logic [15:0] offset;
    logic [31:0] pc_out, rs, rt, stall_cnt;
    logic        s_in_ready, s_fmode1, s_fmode2, s_out_valid, s_fmode1_reg, s_fmode2_reg;
    logic [4:0]  s_reg1, s_reg2, s_rd_no, s_rs_no, s_rt_no;
    logic [5:0]  s_opecode;
    logic [15:0] s_offset;
    logic [31:0] s_pc_out, s_rs, s_rt;
    logic [3:0]  s_stall_cnt;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    decode_pipe #(.XLEN(32), .NFWD(2), .CNTW(32)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .command(command), .reg1(reg1), .reg2(reg2), .fmode1(fmode1), .fmode2(fmode2),
        .reg_out1(reg_out1), .reg_out2(reg_out2), .fwd_valid(fwd_valid), .fwd_no(fwd_no),
        .fwd_fmode(fwd_fmode), .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
        .opecode(opecode), .offset(offset), .pc_out(pc_out), .rs(rs), .rt(rt), .rd_no(rd_no),
        .rs_no(rs_no), .rt_no(rt_no), .fmode1_reg(fmode1_reg), .fmode2_reg(fmode2_reg),
        .stall_cnt(stall_cnt)
    );

    decode_pipe #(.XLEN(32), .NFWD(2), .CNTW(4)) dut4 (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .pc(pc), .command(command), .reg1(s_reg1), .reg2(s_reg2), .fmode1(s_fmode1), .fmode2(s_fmode2),
        .reg_out1(reg_out1), .reg_out2(reg_out2), .fwd_valid(fwd_valid), .fwd_no(fwd_no),
        .fwd_fmode(fwd_fmode), .fwd_data(fwd_data), .out_valid(s_out_valid), .out_ready(out_ready),
        .opecode(s_opecode), .offset(s_offset), .pc_out(s_pc_out), .rs(s_rs), .rt(s_rt), .rd_no(s_rd_no),
        .rs_no(s_rs_no), .rt_no(s_rt_no), .fmode1_reg(s_fmode1_reg), .fmode2_reg(s_fmode2_reg),
        .stall_cnt(s_stall_cnt)
    );

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        return {op, rd, a, b, 11'h0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 0; flush = 0; in_valid = 0; out_ready = 1; fwd_valid = 0; fwd_fmode = 0;
        tick();
        rstn = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        checks++; if (opecode !== 6'h02) begin errors++; $display("FAIL reset_opecode got %h exp 02", opecode); end
        checks++; if ({rs, rt, pc_out} !== 96'h0) begin errors++; $display("FAIL reset_data got %h %h %h exp 0", rs, rt, pc_out); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    endtask

    task automatic test_decode();
        command = mk(6'h00, 5'd7, 5'd4, 5'd9); #1;
        checks++; if ({reg1, reg2} !== {5'd4, 5'd7}) begin errors++; $display("FAIL dec_bank0 got %0d %0d exp 4 7", reg1, reg2); end
        command = mk(6'h04, 5'd7, 5'd4, 5'd9); #1;
        checks++; if (reg2 !== 5'd7) begin errors++; $display("FAIL dec_branch got %0d exp 7", reg2); end
        command = mk(6'h01, 5'd7, 5'd4, 5'd9); #1;
        checks++; if ({reg2, fmode1, fmode2} !== {5'd9, 2'b00}) begin errors++; $display("FAIL dec_alu got %0d %0b%0b exp 9 00", reg2, fmode1, fmode2); end
        command = mk(6'h11, 5'd7, 5'd4, 5'd9); #1;
        checks++; if ({fmode1, fmode2} !== 2'b11) begin errors++; $display("FAIL dec_fp got %0b%0b exp 11", fmode1, fmode2); end
        command = mk(6'h10, 5'd7, 5'd4, 5'd9); #1;
        checks++; if ({reg2, fmode1, fmode2} !== {5'd7, 2'b01}) begin errors++; $display("FAIL dec_fp_bank0 got %0d %0b%0b exp 7 01", reg2, fmode1, fmode2); end
    endtask

    task automatic test_capture();
        do_reset();
        command = 32'h04221800; pc = 32'h1000; reg_out1 = 32'h11; reg_out2 = 32'h22;
        in_valid = 1; out_ready = 1; #1;
        checks++; if ({reg1, reg2, in_ready} !== {5'd2, 5'd3, 1'b1}) begin errors++; $display("FAIL cap_comb got %0d %0d %0b exp 2 3 1", reg1, reg2, in_ready); end
        tick();
        in_valid = 0;
        checks++; if ({out_valid, rs, rt} !== {1'b1, 32'h11, 32'h22}) begin errors++; $display("FAIL cap_ops got %0b %h %h exp 1 11 22", out_valid, rs, rt); end
        checks++; if ({rs_no, rt_no, rd_no} !== {5'd2, 5'd3, 5'd1}) begin errors++; $display("FAIL cap_nos got %0d %0d %0d exp 2 3 1", rs_no, rt_no, rd_no); end
        checks++; if ({opecode, offset, pc_out} !== {6'h01, 16'h1800, 32'h1000}) begin errors++; $display("FAIL cap_fields got %h %h %h exp 01 1800 1000", opecode, offset, pc_out); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cap_drain got %0b exp 0", out_valid); end
    endtask

    task automatic test_priority();
        do_reset();
        reg_out1 = 32'h11; reg_out2 = 32'h22;
        fwd_valid = 2'b11; fwd_fmode = 2'b00; fwd_no = {5'd2, 5'd2}; fwd_data = {32'hB, 32'hA};
        command = mk(6'h01, 5'd0, 5'd2, 5'd3); in_valid = 1;
        tick();
        checks++; if ({rs, rt} !== {32'hA, 32'h22}) begin errors++; $display("FAIL prio_low got %h %h exp a 22", rs, rt); end
        fwd_no = {5'd0, 5'd0}; command = mk(6'h01, 5'd0, 5'd0, 5'd3);
        tick();
        checks++; if (rs !== 32'h11) begin errors++; $display("FAIL prio_r0 got %h exp 11", rs); end
        fwd_no = {5'd2, 5'd2}; fwd_valid = 2'b10; command = mk(6'h01, 5'd0, 5'd2, 5'd3);
        tick();
        checks++; if (rs !== 32'hB) begin errors++; $display("FAIL prio_p1 got %h exp b", rs); end
        fwd_valid = 2'b11; fwd_no = {5'd0, 5'd0}; fwd_fmode = 2'b01; command = mk(6'h11, 5'd0, 5'd0, 5'd3);
        tick();
        checks++; if ({rs, rt} !== {32'hA, 32'h22}) begin errors++; $display("FAIL prio_fp0 got %h %h exp a 22", rs, rt); end
        fwd_fmode = 2'b01; fwd_no = {5'd3, 5'd3}; command = mk(6'h01, 5'd0, 5'd3, 5'd4);
        tick();
        checks++; if (rs !== 32'hB) begin errors++; $display("FAIL prio_bank got %h exp b", rs); end
        in_valid = 0; fwd_valid = 0; fwd_fmode = 0;
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        reg_out1 = 32'h1; reg_out2 = 32'h2; fwd_valid = 0;
        command = mk(6'h01, 5'd0, 5'd5, 5'd6); in_valid = 1; out_ready = 1;
        tick();
        out_ready = 0; command = mk(6'h03, 5'd0, 5'd7, 5'd8); #1;
        checks++; if ({out_valid, rs, in_ready} !== {1'b1, 32'h1, 1'b0}) begin errors++; $display("FAIL stall_enter got %0b %h %0b exp 1 1 0", out_valid, rs, in_ready); end
        tick();
        checks++; if ({rs, stall_cnt} !== {32'h1, 32'd1}) begin errors++; $display("FAIL stall_c1 got %h %0d exp 1 1", rs, stall_cnt); end
        fwd_valid = 2'b10; fwd_fmode = 2'b00; fwd_no = {5'd5, 5'd0}; fwd_data = {32'h55, 32'h0};
        tick();
        fwd_valid = 0;
        checks++; if ({rs, rt, stall_cnt} !== {32'h55, 32'h2, 32'd2}) begin errors++; $display("FAIL stall_c2 got %h %h %0d exp 55 2 2", rs, rt, stall_cnt); end
        tick();
        checks++; if ({rs, stall_cnt, in_ready, out_valid} !== {32'h55, 32'd3, 2'b01}) begin errors++; $display("FAIL stall_c3 got %h %0d %0b %0b exp 55 3 0 1", rs, stall_cnt, in_ready, out_valid); end
        checks++; if ({opecode, rs_no} !== {6'h01, 5'd5}) begin errors++; $display("FAIL stall_hold got %h %0d exp 01 5", opecode, rs_no); end
        flush = 1;
        tick();
        checks++; if ({out_valid, opecode, in_ready} !== {1'b0, 6'h02, 1'b1}) begin errors++; $display("FAIL flush_stall got %0b %h %0b exp 0 02 1", out_valid, opecode, in_ready); end
        checks++; if (stall_cnt !== 32'd4) begin errors++; $display("FAIL flush_cnt got %0d exp 4", stall_cnt); end
        out_ready = 1;
        tick();
        checks++; if ({out_valid, opecode} !== {1'b0, 6'h02}) begin errors++; $display("FAIL flush_cap got %0b %h exp 0 02", out_valid, opecode); end
        flush = 0;
        tick();
        checks++; if ({out_valid, opecode} !== {1'b1, 6'h03}) begin errors++; $display("FAIL post_flush got %0b %h exp 1 03", out_valid, opecode); end
        in_valid = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        reg_out1 = 32'h77; command = mk(6'h01, 5'd1, 5'd2, 5'd3); in_valid = 1; out_ready = 1;
        tick();
        out_ready = 0;
        tick(); tick();
        rstn = 0;
        tick();
        rstn = 1; in_valid = 0;
        checks++; if ({out_valid, opecode, rs, stall_cnt} !== {1'b0, 6'h02, 32'h0, 32'd0}) begin errors++; $display("FAIL rst_mid got %0b %h %h %0d exp 0 02 0 0", out_valid, opecode, rs, stall_cnt); end
        checks++; if ({rs_no, rd_no, offset, pc_out} !== 58'h0) begin errors++; $display("FAIL rst_mid_fields got %0d %0d %h %h exp 0", rs_no, rd_no, offset, pc_out); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_drop got %0b exp 0", out_valid); end
    endtask

    task automatic test_saturate();
        do_reset();
        command = mk(6'h01, 5'd0, 5'd2, 5'd3); in_valid = 1; out_ready = 1;
        tick();
        in_valid = 0; out_ready = 0;
        for (int i = 0; i < 20; i++) tick();
        checks++; if (stall_cnt !== 32'd20) begin errors++; $display("FAIL sat_wide got %0d exp 20", stall_cnt); end
        checks++; if (s_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt4 got %0d exp 15", s_stall_cnt); end
        out_ready = 1;
        tick();
        checks++; if ({out_valid, s_stall_cnt} !== {1'b0, 4'd15}) begin errors++; $display("FAIL sat_hold got %0b %0d exp 0 15", out_valid, s_stall_cnt); end
    endtask

    initial begin
        #1;
        test_reset();
        test_decode();
        test_capture();
        test_priority();
        test_stall();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
